dx_spi_slave: RTL
=================

# dx_spi_slave

SPI target (slave) endpoint: the responder side of the `dx_spi_core` initiator, fully oversampled in the FPGA `clk` domain. Synchronizes external `sclk`/`csn`/`mosi`, decodes CPOL/CPHA edges, shifts in up to `DATA_WIDTH` bits from MOSI while shifting out a preloaded word on MISO, and strobes the received word to fabric logic. Sits between the board SPI pins and register-file or FIFO logic that answers an external or on-chip master.

## Interface
- `DATA_WIDTH`, 32: maximum bits per frame.
- `DATA_COUNT_WIDTH`, 8: bit-counter width; (2^DATA_COUNT_WIDTH)-1 >= DATA_WIDTH.
- `clk`  in  1  system clock; sole clock of the block.
- `rst`  in  1  reset, asynchronous, active-high.
- `spi_width_i`  in  DATA_COUNT_WIDTH  bits per frame, 1..DATA_WIDTH; captured at frame start.
- `cpol_i`  in  1  sclk idle level; captured at frame start.
- `cpha_i`  in  1  0: sample on leading edge; 1: sample on trailing edge; captured at frame start.
- `tx_data_i`  in  DATA_WIDTH  reply word; top `spi_width` bits sent MSB first; captured at frame start.
- `tx_load_o`  out  1  one-cycle pulse on the cycle `tx_data_i` is captured.
- `rx_stb`  out  1  one-cycle pulse: frame of `spi_width` bits complete.
- `rx_data_o`  out  DATA_WIDTH  received bits, right-justified in low `spi_width` bits, upper bits 0; held until next frame start.
- `abort_o`  out  1  one-cycle pulse: `csn` rose before frame complete.
- `busy_o`  out  1  high from frame start until return to ST_IDLE.
- `state_o`  out  3  registered copy of state, one cycle late.
- `data_count_o`  out  DATA_COUNT_WIDTH  bits sampled in current frame.
- `sclk`, `csn`, `mosi`  in  1 each  pins, asynchronous to `clk`.
- `miso`  out  1  serial data to master.

## Operation
- Pins pass through 2-FF synchronizers; edges detected on synchronized samples. Leading edge = `sclk` leaving `cpol`; trailing edge = returning to `cpol`.
- States: ST_IDLE(0), ST_LOAD(1), ST_SHIFT(2), ST_DONE(3).
- ST_IDLE: `miso` released, `busy_o`=0. Synchronized `csn` falling edge -> ST_LOAD.
- ST_LOAD (one cycle): capture `spi_width_i`, `cpol_i`, `cpha_i`, `tx_data_i`; pulse `tx_load_o`; clear `rx_data_o` and `data_count_o`; CPHA=0 drives `miso` = tx MSB. -> ST_SHIFT.
- ST_SHIFT: on each sample edge, shift synchronized `mosi` into LSB and increment `data_count`. On each drive edge, put next tx bit on `miso` (CPHA=0: trailing edges; CPHA=1: leading edges, first one puts MSB). When `data_count` reaches `spi_width` at a sample edge, pulse `rx_stb` the following cycle and go to ST_DONE.
- ST_DONE: further `sclk` edges ignored; `miso` holds last bit. `csn` rise -> ST_IDLE.
- `csn` rise in ST_LOAD/ST_SHIFT: pulse `abort_o`, no `rx_stb`, `rx_data_o` keeps partial bits, -> ST_IDLE.
- `csn` fall in ST_DONE impossible (no rise seen); `csn` rise and final sample edge in same cycle: sample taken, `rx_stb` issued, no `abort_o`.
- `spi_width` 0 or > DATA_WIDTH: treated as DATA_WIDTH.
- `rst` mid-frame: immediate return to reset values; the remainder of that frame (until `csn` rises) is ignored.
- Reset values: `miso` released, `rx_stb`/`abort_o`/`tx_load_o`/`busy_o` 0, `rx_data_o` 0, `data_count_o` 0, `state_o` ST_IDLE.

## Timing
- Pin-to-decision latency: 3 `clk` (2 sync + edge register).
- `sclk` high and low times each >= 4 `clk` periods; `csn` fall to first `sclk` edge >= 4 `clk` (master `sclk_div` >= 2 at equal clocks).
- `miso` update: 3 `clk` after the pin drive edge; must settle before the master's next sample edge.
- `rx_stb` at 4 `clk` after the final sample edge at the pin.
- `tx_data_i` needed only on the ST_LOAD cycle, 4 `clk` after `csn` fall at the pin.

## Configuration
- `DX_SPI_SLAVE_MISO_TRISTATE_EN` defined: `miso` = 1'bz whenever not selected (ST_IDLE or `csn` high), for shared-bus boards.
- Undefined: `miso` driven 0 when not selected; no tristate inferred.

## Structure
- Package `dx_spi_pkg`: state constants ST_IDLE..ST_DONE, state width 3, SPI mode encoding {cpol,cpha}; shared with `dx_spi_core`.
- Sub-module `dx_spi_sync`: 2-FF synchronizer plus rise/fall edge pulses for one input, instantiated for `sclk`, `csn`, `mosi`.

## Test plan
- Mode 0, width 8, tx 0xA5000000, master `dx_spi_core` sends 0x3C000000 with sclk_div 3 -> `rx_data_o`=0x3C, master receives 0xA5, one `rx_stb`.
- Modes 1, 2, 3 with the same words -> identical results in each mode.
- Width 32, tx 0xDEADBEEF, master sends 0x12345678 -> `rx_data_o`=0x12345678, master receives 0xDEADBEEF.
- `csn` raised after 5 of 8 bits, mosi all 1 -> `abort_o` pulse, no `rx_stb`, `rx_data_o`=0x1F, back in ST_IDLE.
- 10 sclk cycles with width 8 -> `rx_stb` after bit 8, edges 9-10 ignored, `data_count_o`=8.
- `rst` asserted mid-frame, then new frame -> outputs at reset values, next frame received correctly.

Source files
------------

// File: rtl/dx_spi_pkg.sv
// Shared SPI definitions for dx_spi_core / dx_spi_slave: FSM state
// encoding, state width and the {cpol,cpha} mode encoding.
package dx_spi_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_DONE  = 3'd3
  } state_e;

  typedef enum logic [1:0] {
    SPI_MODE0 = 2'b00,
    SPI_MODE1 = 2'b01,
    SPI_MODE2 = 2'b10,
    SPI_MODE3 = 2'b11
  } spi_mode_e;

  // Pack idle level and phase into the mode encoding.
  function automatic spi_mode_e spi_mode(input logic cpol, input logic cpha);
    return spi_mode_e'({cpol, cpha});
  endfunction

endpackage

// File: rtl/dx_spi_slave_if.sv
// SPI pin bundle.
//   sclk, csn, mosi : driven by the master
//   miso            : driven by the slave
// modport slave  : target side (dx_spi_slave)
// modport master : initiator side (dx_spi_core or a bench)
interface dx_spi_slave_if;
  logic sclk;
  logic csn;
  logic mosi;
  logic miso;

  modport slave  (input sclk, csn, mosi, output miso);
  modport master (output sclk, csn, mosi, input miso);
endinterface

// File: rtl/dx_spi_sync.sv
// Two-flop synchronizer for one asynchronous pin plus edge detection.
//   clk, rst : system clock, async active-high reset
//   d_i      : asynchronous pin
//   level_o  : synchronized level
//   rise_c   : one-cycle pulse on a synchronized rising edge
//   fall_c   : one-cycle pulse on a synchronized falling edge
module dx_spi_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic level_o,
  output logic rise_c,
  output logic fall_c
);

  logic meta_q, sync_q, prev_q;
  logic meta_d, sync_d, prev_d;

  // Shift chain: pin -> meta -> sync -> prev (edge register).
  always_comb begin
    meta_d = d_i;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level_o = sync_q;
  assign rise_c  = sync_q & ~prev_q;
  assign fall_c  = ~sync_q & prev_q;

endmodule

// File: rtl/dx_spi_slave.sv
// SPI target endpoint, fully oversampled in the clk domain.
// Receives up to DATA_WIDTH bits MSB first from MOSI while returning the
// word captured from tx_data_i on MISO; strobes the received word.
//   clk, rst          : system clock, async active-high reset
//   spi_width_i       : bits per frame (0 or >DATA_WIDTH means DATA_WIDTH)
//   cpol_i, cpha_i    : SPI mode, captured at frame start
//   tx_data_i         : reply word, top spi_width bits sent
//   tx_load_o         : pulse on the cycle tx_data_i is captured
//   rx_stb / rx_data_o: frame complete / received bits, right-justified
//   abort_o           : csn rose before the frame completed
//   busy_o, state_o   : activity flag / state delayed one cycle
//   data_count_o      : bits sampled in the current frame
//   spi               : pin bundle (slave modport)
// Build option: DX_SPI_SLAVE_MISO_TRISTATE_EN releases miso to 1'bz when
// not selected; otherwise miso is driven 0 when not selected.
module dx_spi_slave
  import dx_spi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned DATA_COUNT_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_COUNT_WIDTH-1:0] spi_width_i,
  input  logic                        cpol_i,
  input  logic                        cpha_i,
  input  logic [DATA_WIDTH-1:0]       tx_data_i,
  output logic                        tx_load_o,
  output logic                        rx_stb,
  output logic [DATA_WIDTH-1:0]       rx_data_o,
  output logic                        abort_o,
  output logic                        busy_o,
  output logic [STATE_W-1:0]          state_o,
  output logic [DATA_COUNT_WIDTH-1:0] data_count_o,
  dx_spi_slave_if.slave               spi
);

  localparam logic [DATA_COUNT_WIDTH-1:0] FULL_CNT = DATA_COUNT_WIDTH'(DATA_WIDTH);

  logic sclk_rise_c, sclk_fall_c, csn_rise_c, csn_fall_c, mosi_s, csn_s;
  logic unused_sclk_lvl, unused_mosi_rise, unused_mosi_fall;

  dx_spi_sync u_sync_sclk (.clk(clk), .rst(rst), .d_i(spi.sclk),
                           .level_o(unused_sclk_lvl), .rise_c(sclk_rise_c), .fall_c(sclk_fall_c));
  dx_spi_sync u_sync_csn  (.clk(clk), .rst(rst), .d_i(spi.csn),
                           .level_o(csn_s), .rise_c(csn_rise_c), .fall_c(csn_fall_c));
  dx_spi_sync u_sync_mosi (.clk(clk), .rst(rst), .d_i(spi.mosi),
                           .level_o(mosi_s), .rise_c(unused_mosi_rise), .fall_c(unused_mosi_fall));

  state_e                      state_q, state_d;
  spi_mode_e                   mode_q, mode_d;
  logic [DATA_COUNT_WIDTH-1:0] width_q, width_d, count_q, count_d;
  logic [DATA_WIDTH-1:0]       tx_q, tx_d, rx_q, rx_d;
  logic                        miso_q, miso_d;
  logic                        final_q, final_d, abort_q, abort_d;
  logic                        rx_stb_q, busy_q, tx_load_q;
  logic [STATE_W-1:0]          state_o_q;

  logic [DATA_COUNT_WIDTH-1:0] width_eff_c;
  logic                        lead_c, trail_c, sample_c, drive_c;

  assign width_eff_c = (spi_width_i == '0 || spi_width_i > FULL_CNT) ? FULL_CNT : spi_width_i;

  // Leading edge leaves the idle level; CPHA picks which edge samples.
  assign lead_c   = mode_q[1] ? sclk_fall_c : sclk_rise_c;
  assign trail_c  = mode_q[1] ? sclk_rise_c : sclk_fall_c;
  assign sample_c = mode_q[0] ? trail_c : lead_c;
  assign drive_c  = mode_q[0] ? lead_c  : trail_c;

  // Next-state and datapath.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    width_d = width_q;
    count_d = count_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    miso_d  = miso_q;
    final_d = 1'b0;
    abort_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (csn_fall_c) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        mode_d  = spi_mode(cpol_i, cpha_i);
        width_d = width_eff_c;
        count_d = '0;
        rx_d    = '0;
        // CPHA=0 presents the MSB before the first edge; CPHA=1 drives it on the first leading edge.
        if (cpha_i) begin
          tx_d   = tx_data_i;
          miso_d = 1'b0;
        end else begin
          tx_d   = {tx_data_i[DATA_WIDTH-2:0], 1'b0};
          miso_d = tx_data_i[DATA_WIDTH-1];
        end
        abort_d = csn_rise_c;
        state_d = csn_rise_c ? ST_IDLE : ST_SHIFT;
      end
      ST_SHIFT: begin
        if (drive_c) begin
          miso_d = tx_q[DATA_WIDTH-1];
          tx_d   = {tx_q[DATA_WIDTH-2:0], 1'b0};
        end
        if (sample_c) begin
          rx_d    = {rx_q[DATA_WIDTH-2:0], mosi_s};
          count_d = count_q + DATA_COUNT_WIDTH'(1);
        end
        // A final sample wins over a simultaneous csn rise.
        if (sample_c && count_d == width_q) begin
          final_d = 1'b1;
          state_d = csn_rise_c ? ST_IDLE : ST_DONE;
        end else if (csn_rise_c) begin
          abort_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_DONE: begin
        if (csn_rise_c) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      mode_q    <= SPI_MODE0;
      width_q   <= '0;
      count_q   <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      miso_q    <= 1'b0;
      final_q   <= 1'b0;
      abort_q   <= 1'b0;
      rx_stb_q  <= 1'b0;
      busy_q    <= 1'b0;
      tx_load_q <= 1'b0;
      state_o_q <= ST_IDLE;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      width_q   <= width_d;
      count_q   <= count_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      miso_q    <= miso_d;
      final_q   <= final_d;
      abort_q   <= abort_d;
      rx_stb_q  <= final_q;
      busy_q    <= (state_d != ST_IDLE);
      tx_load_q <= (state_d == ST_LOAD);
      state_o_q <= state_q;
    end
  end

  assign tx_load_o    = tx_load_q;
  assign rx_stb       = rx_stb_q;
  assign rx_data_o    = rx_q;
  assign abort_o      = abort_q;
  assign busy_o       = busy_q;
  assign state_o      = state_o_q;
  assign data_count_o = count_q;

`ifdef DX_SPI_SLAVE_MISO_TRISTATE_EN
  assign spi.miso = (state_q == ST_IDLE || csn_s) ? 1'bz : miso_q;
`else
  assign spi.miso = (state_q == ST_IDLE || csn_s) ? 1'b0 : miso_q;
`endif

endmodule
